seq_detector_prog: RTL
======================

// Module: seq_detector_prog
// PURPOSE
//  Programmable serial bit-sequence detector; successor to the fixed 5-state detector.
//  Replaces the hard-coded FSM with a run-time loadable pattern of 1..MAX_LEN bits.
//  Adds an input-valid qualifier, overlapping/non-overlapping match modes and a
//  saturating match counter.
//  Sits between a serial bit source and control/status logic in the sequence_detector design.
// PARAMETERS
//  MAX_LEN          8             longest supported pattern, in bits (>=2)
//  DEFAULT_PATTERN  8'b0000_1101  pattern after reset; bit0 = newest (last-received) bit
//  DEFAULT_LEN      4             pattern length after reset (1..MAX_LEN)
//  DEFAULT_OVERLAP  1             1 = overlapping matches allowed after reset
//  CNT_W            16            width of match_count
// PORTS
//  clk           in   1                      clock; all state updates on posedge
//  rst           in   1                      reset, synchronous, active-high
//  in_valid      in   1                      in_bit is consumed this cycle
//  in_bit        in   1                      serial data bit
//  cfg_we        in   1                      load cfg_* and restart detection
//  cfg_pattern   in   MAX_LEN                new pattern; bit0 = newest bit
//  cfg_len       in   $clog2(MAX_LEN+1)      new pattern length
//  cfg_overlap   in   1                      new overlap mode
//  count_clr     in   1                      clear match_count
//  match         out  1                      one-cycle pulse per detected pattern
//  match_count   out  CNT_W                  saturating count of matches
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - pat_q=DEFAULT_PATTERN, len_q=DEFAULT_LEN, ovl_q=DEFAULT_OVERLAP.
//   - hist=0, fill=0, match=0, match_count=0.
//   - rst overrides every other input in that cycle.
//  Config (cfg_we=1):
//   - Loads pat_q, len_q, ovl_q; clears hist and fill; match<=0.
//   - A simultaneous in_valid bit is discarded. match_count is not affected.
//   - cfg_len=0 is loaded as 1; cfg_len>MAX_LEN is loaded as MAX_LEN.
//  Shift (in_valid=1, cfg_we=0):
//   - hist_n = {hist[MAX_LEN-2:0], in_bit}.
//   - fill_n = min(fill+1, MAX_LEN).
//   - hit = (fill_n >= len_q) && (hist_n[len_q-1:0] == pat_q[len_q-1:0]).
//   - Compare only the low len_q bits; pat_q bits above len_q are ignored.
//   - hist<=hist_n; match<=hit; registered, so match is high in the cycle after the
//     completing bit is sampled (latency 1).
//   - hit && ovl_q==0: fill<=0 (the next match needs len_q fresh bits).
//     Otherwise fill<=fill_n.
//  Idle (in_valid=0, cfg_we=0): hist and fill hold; match<=0.
//   - Gaps in in_valid never break a partial sequence.
//  match_count:
//   - Increments on each hit; holds at all-ones (no wrap).
//   - count_clr=1 forces 0 and takes priority over a simultaneous hit.
//   - That hit still pulses match but is not counted.
//  No combinational path from inputs to outputs.
// TESTING
//  1 Defaults, overlap: stream 1,1,0,1,1,0,1 (in_valid=1 every cycle)
//    -> match after bits 4 and 7; match_count=2.
//  2 cfg_overlap=0, pattern 1101, len 4; same stream -> match after bit 4 only; match_count=1.
//  3 Defaults; stream 1,1,0,1 with 3 idle cycles between each bit
//    -> one match pulse, one cycle after the 4th valid bit; no other pulses.
//  4 After bits 1,1,0: cfg_we with pattern 3'b010, len 3.
//    Then 0,1,0,1,0 -> matches after the 3rd and 5th bits; the earlier partial 1101 never fires.
//  5 CNT_W=2: 5 matches -> match_count 1,2,3,3,3.
//    count_clr concurrent with a hit -> count 0, match still 1.
//  6 rst asserted after bits 1,1,0; then 1 -> no match.
//    Then a fresh 1,1,0,1 -> match; all outputs 0 during rst.

Source files
------------

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - programmable serial bit-sequence detector
// Loadable pattern of 1..MAX_LEN bits with overlap control and a saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN         = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1101,
  parameter int                 DEFAULT_LEN     = 4,
  parameter bit                 DEFAULT_OVERLAP = 1'b1,
  parameter int                 CNT_W           = 16,
  localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    count_d = count_q;

    hist_n = {hist_q[MAX_LEN-2:0], in_bit};
    fill_n = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;
    // Only the low len_q bits of the history take part in the compare.
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    hit = in_valid && !cfg_we && (fill_n >= len_q) &&
          (((hist_n ^ pat_q) & mask) == '0);

    if (cfg_we) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      if (cfg_len == '0) begin
        len_d = LEN_W'(1);
      end else if (cfg_len > MAX_LEN_L) begin
        len_d = MAX_LEN_L;
      end else begin
        len_d = cfg_len;
      end
    end else if (in_valid) begin
      hist_d  = hist_n;
      match_d = hit;
      fill_d  = (hit && !ovl_q) ? '0 : fill_n;
    end

    if (count_clr) begin
      count_d = '0;
    end else if (hit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= LEN_W'(DEFAULT_LEN);
      ovl_q   <= DEFAULT_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;

endmodule
